hy_frame_buffer: RTL and testbench
==================================

Name: hy_frame_buffer

Overview:
Ping-pong frame store directly downstream of the UART command decoder. It captures the 16-element complex H matrix and the 8-element complex Y vector, which arrive as single-cycle H_valid/Y_valid pulses, into one of two banks. A completed bank is then offered to the detector core through a registered random-access read port with a ready/ack handshake. While the core works on one frame, the UART can load the next frame into the other bank.

Parameters:
N, 32, width of each real/imag component
H_ELEMS, 16, H elements per frame (4x4, row-major, write order = address)
Y_ELEMS, 8, Y elements per frame

Ports:
CLOCK_50  in  1  system clock
sw_0  in  1  asynchronous active-low reset (0 = reset, 1 = run)
sys_start  in  1  pulse; marks the first byte of a new frame
H_valid  in  1  pulse; H_r/H_i valid this cycle
H_r  in  N  H real part
H_i  in  N  H imag part
Y_valid  in  1  pulse; Y_r/Y_i valid this cycle
Y_r  in  N  Y real part
Y_i  in  N  Y imag part
frame_ready  out  1  read bank holds a complete frame
frame_ack  in  1  pulse from core; releases the read bank
rd_sel  in  1  0 = H array, 1 = Y array
rd_addr  in  4  element index
rd_r  out  N  read data real part, registered
rd_i  out  N  read data imag part, registered
seq_err  out  1  sticky; protocol-order violation
drop_err  out  1  sticky; data lost because no bank was free
frames_done  out  8  count of acked frames, wraps 255 -> 0

Behaviour:
- Reset (sw_0 = 0, asynchronous):
  - all outputs are 0; both banks EMPTY; wr_bank = rd_bank = 0; write counters cleared.
  - storage contents need not be cleared.
- Bank status per bank: EMPTY -> FILLING -> FULL -> EMPTY.
  - EMPTY -> FILLING on the first accepted write.
  - FILLING -> FULL on the write of the final Y element.
  - FULL -> EMPTY on a frame_ack that applies to that bank.
- Write side uses counters h_cnt (0..16) and y_cnt (0..8) for wr_bank.
- sys_start:
  - If wr_bank is not FULL: h_cnt = y_cnt = 0, bank becomes EMPTY, seq_err and drop_err clear. Any partial frame is discarded.
  - If wr_bank is FULL: sys_start is ignored and drop_err is set.
  - If sys_start and H_valid occur in the same cycle, the clear applies first and the H write lands at index 0.
- H_valid:
  - Accepted if wr_bank is not FULL and h_cnt < 16. Writes H[h_cnt] and increments h_cnt.
  - If h_cnt == 16, the write is ignored and seq_err is set.
  - If wr_bank is FULL, the write is ignored and drop_err is set.
- Y_valid:
  - Accepted only if h_cnt == 16 and y_cnt < 8. Writes Y[y_cnt] and increments y_cnt.
  - If h_cnt < 16, the write is ignored and seq_err is set.
  - If wr_bank is FULL, the write is ignored and drop_err is set.
  - On the 8th accepted Y: the bank becomes FULL, wr_bank toggles, and both counters clear, all at the same clock edge.
- Simultaneous H_valid and Y_valid: H is processed, Y is dropped, seq_err is set.
- frame_ready:
  - Equals (status[rd_bank] == FULL) and not ack_block.
  - It first goes high in the cycle after the edge that sampled the final Y_valid.
- frame_ack:
  - Honoured only while frame_ready = 1. It sets status[rd_bank] to EMPTY, toggles rd_bank, and increments frames_done, all at the same edge.
  - ack_block is set for one cycle, so frame_ready is low for at least one cycle even if the other bank is already FULL.
  - frame_ack while frame_ready = 0 is ignored with no error.
- Simultaneous frame completion (write) and frame_ack (read bank) in the same cycle: both take effect.
  - This holds even when they target the same bank index after the toggles; the next state is computed from current-state values.
- Read port:
  - rd_r/rd_i are registered from bank[rd_bank] at (rd_sel, rd_addr), with 1-cycle latency.
  - Data is valid only while frame_ready was high in the sampling cycle; otherwise the content is undefined but stable.
  - rd_sel = 1 with rd_addr >= 8 returns 0.
- A bank is never written while FULL. Therefore read data is stable between frame_ready rising and frame_ack.
- Reset mid-frame aborts everything, with no pending outputs.
- Storage: 2 banks x 24 entries x 2N bits, as registers or inferred RAM. Synchronous write; the read register sits outside any reset requirement except rd_r/rd_i = 0 at reset.

Test Plan:
- Basic frame: send sys_start, then H[k] = (k, 100+k) for k = 0..15, then Y[j] = (200+j, 300+j) for j = 0..7. Required: frame_ready rises 1 cycle after the final Y_valid; reading H addr 5 gives (5, 105); reading Y addr 7 gives (207, 307) one cycle after the address; seq_err = drop_err = 0.
- Ack release: after frame 1, pulse frame_ack. Required: frame_ready falls, frames_done = 1, and frame_ready stays low because bank 1 is EMPTY.
- Ping-pong: load frame A (values offset 0) and, without acking, frame B (offset 1000), then ack. Required: frame_ready is low for exactly 1 cycle, then B is readable (H addr 0 = (1000, 1100)) and frames_done = 1.
- Overrun: with both banks FULL, send a third frame. Required: drop_err = 1, bank contents unchanged, sys_start ignored.
- Sequencing errors:
  - Y_valid after only 10 H elements: Y is ignored, seq_err = 1, and the subsequent H writes continue at index 10.
  - A 17th H is ignored.
  - A following sys_start clears seq_err.
- Abort and reset: sys_start after 20 elements restarts at index 0 and the next frame completes correctly. Pulling sw_0 low mid-frame sets all outputs to 0 immediately (asynchronously), and frames_done = 0.

Source files
------------

// File: rtl/hy_frame_buffer.sv
// Ping-pong H/Y frame store between the UART command decoder and the detector core.
// The UART fills one bank while the core reads the other through a registered port.
module hy_frame_buffer #(
  parameter int N       = 32,
  parameter int H_ELEMS = 16,
  parameter int Y_ELEMS = 8
) (
  input  logic         CLOCK_50,
  input  logic         sw_0,
  input  logic         sys_start,
  input  logic         H_valid,
  input  logic [N-1:0] H_r,
  input  logic [N-1:0] H_i,
  input  logic         Y_valid,
  input  logic [N-1:0] Y_r,
  input  logic [N-1:0] Y_i,
  output logic         frame_ready,
  input  logic         frame_ack,
  input  logic         rd_sel,
  input  logic [3:0]   rd_addr,
  output logic [N-1:0] rd_r,
  output logic [N-1:0] rd_i,
  output logic         seq_err,
  output logic         drop_err,
  output logic [7:0]   frames_done
);

  localparam int HW    = $clog2(H_ELEMS + 1);
  localparam int YW    = $clog2(Y_ELEMS + 1);
  localparam int YA    = $clog2(Y_ELEMS);
  localparam int DEPTH = H_ELEMS + Y_ELEMS;
  localparam int AW    = $clog2(DEPTH);

  typedef enum logic [1:0] {ST_EMPTY, ST_FILLING, ST_FULL} bank_st_t;

  logic rst_n;
  assign rst_n = sw_0;

  bank_st_t        status_q [2];
  bank_st_t        status_d [2];
  logic [HW-1:0]   h_cnt, h_cnt_d, h_eff;
  logic [YW-1:0]   y_cnt, y_cnt_d, y_eff;
  logic            wr_bank, wr_bank_d;
  logic            rd_bank, rd_bank_d;
  logic            ack_block, ack_block_d;
  logic            seq_err_d, drop_err_d;
  logic [7:0]      frames_done_d;
  logic            wr_full, clr;
  logic            we;
  logic [AW-1:0]   waddr;
  logic [2*N-1:0]  wdata;
  logic [AW-1:0]   raddr;
  logic            rd_zero;
  logic [2*N-1:0]  mem [2][DEPTH];

  assign frame_ready = (status_q[rd_bank] == ST_FULL) && !ack_block;

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      status_q[0] <= ST_EMPTY;
      status_q[1] <= ST_EMPTY;
      h_cnt       <= '0;
      y_cnt       <= '0;
      wr_bank     <= 1'b0;
      rd_bank     <= 1'b0;
      ack_block   <= 1'b0;
      seq_err     <= 1'b0;
      drop_err    <= 1'b0;
      frames_done <= '0;
    end else begin
      status_q[0] <= status_d[0];
      status_q[1] <= status_d[1];
      h_cnt       <= h_cnt_d;
      y_cnt       <= y_cnt_d;
      wr_bank     <= wr_bank_d;
      rd_bank     <= rd_bank_d;
      ack_block   <= ack_block_d;
      seq_err     <= seq_err_d;
      drop_err    <= drop_err_d;
      frames_done <= frames_done_d;
    end
  end

  always_comb begin
    status_d[0]   = status_q[0];
    status_d[1]   = status_q[1];
    h_cnt_d       = h_cnt;
    y_cnt_d       = y_cnt;
    wr_bank_d     = wr_bank;
    rd_bank_d     = rd_bank;
    ack_block_d   = 1'b0;
    seq_err_d     = seq_err;
    drop_err_d    = drop_err;
    frames_done_d = frames_done;
    we            = 1'b0;
    waddr         = '0;
    wdata         = '0;

    wr_full = (status_q[wr_bank] == ST_FULL);
    // A restart clears the counters before a same-cycle write is placed.
    clr     = sys_start && !wr_full;
    h_eff   = clr ? '0 : h_cnt;
    y_eff   = clr ? '0 : y_cnt;

    if (sys_start) begin
      if (wr_full) begin
        drop_err_d = 1'b1;
      end else begin
        h_cnt_d           = '0;
        y_cnt_d           = '0;
        status_d[wr_bank] = ST_EMPTY;
        seq_err_d         = 1'b0;
        drop_err_d        = 1'b0;
      end
    end

    if (H_valid) begin
      if (wr_full) begin
        drop_err_d = 1'b1;
      end else if (h_eff < HW'(H_ELEMS)) begin
        we                = 1'b1;
        waddr             = AW'(h_eff);
        wdata             = {H_r, H_i};
        h_cnt_d           = h_eff + 1'b1;
        status_d[wr_bank] = ST_FILLING;
      end else begin
        seq_err_d = 1'b1;
      end
      if (Y_valid) seq_err_d = 1'b1;
    end else if (Y_valid) begin
      if (wr_full) begin
        drop_err_d = 1'b1;
      end else if (h_eff == HW'(H_ELEMS) && y_eff < YW'(Y_ELEMS)) begin
        we    = 1'b1;
        waddr = AW'(H_ELEMS) + AW'(y_eff);
        wdata = {Y_r, Y_i};
        if (y_eff == YW'(Y_ELEMS - 1)) begin
          status_d[wr_bank] = ST_FULL;
          wr_bank_d         = ~wr_bank;
          h_cnt_d           = '0;
          y_cnt_d           = '0;
        end else begin
          y_cnt_d           = y_eff + 1'b1;
          status_d[wr_bank] = ST_FILLING;
        end
      end else begin
        seq_err_d = 1'b1;
      end
    end

    // The read bank is always FULL here, so it never collides with the write bank.
    if (frame_ack && frame_ready) begin
      status_d[rd_bank] = ST_EMPTY;
      rd_bank_d         = ~rd_bank;
      frames_done_d     = frames_done + 8'd1;
      ack_block_d       = 1'b1;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (we) mem[wr_bank][waddr] <= wdata;
  end

  assign rd_zero = rd_sel && (rd_addr >= 4'(Y_ELEMS));
  assign raddr   = rd_sel ? (AW'(H_ELEMS) + AW'(rd_addr[YA-1:0])) : AW'(rd_addr);

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      rd_r <= '0;
      rd_i <= '0;
    end else if (rd_zero) begin
      rd_r <= '0;
      rd_i <= '0;
    end else begin
      {rd_r, rd_i} <= mem[rd_bank][raddr];
    end
  end

endmodule

// File: tb/tb_hy_frame_buffer.sv
// Directed bench for hy_frame_buffer: frame load, ack, ping-pong, overrun,
// sequencing errors, abort and asynchronous reset.
module tb_hy_frame_buffer;

  logic        CLOCK_50 = 1'b0;
  logic        sw_0;
  logic        sys_start, H_valid, Y_valid, frame_ack, rd_sel;
  logic [31:0] H_r, H_i, Y_r, Y_i;
  logic [3:0]  rd_addr;
  logic        frame_ready, seq_err, drop_err;
  logic [31:0] rd_r, rd_i;
  logic [7:0]  frames_done;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 CLOCK_50 = ~CLOCK_50;

  hy_frame_buffer dut (
    .CLOCK_50    (CLOCK_50),
    .sw_0        (sw_0),
    .sys_start   (sys_start),
    .H_valid     (H_valid),
    .H_r         (H_r),
    .H_i         (H_i),
    .Y_valid     (Y_valid),
    .Y_r         (Y_r),
    .Y_i         (Y_i),
    .frame_ready (frame_ready),
    .frame_ack   (frame_ack),
    .rd_sel      (rd_sel),
    .rd_addr     (rd_addr),
    .rd_r        (rd_r),
    .rd_i        (rd_i),
    .seq_err     (seq_err),
    .drop_err    (drop_err),
    .frames_done (frames_done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic start();
    sys_start = 1'b1;
    tick();
    sys_start = 1'b0;
  endtask

  task automatic send_h(input int r, input int i);
    H_valid = 1'b1; H_r = r; H_i = i;
    tick();
    H_valid = 1'b0;
  endtask

  task automatic send_y(input int r, input int i);
    Y_valid = 1'b1; Y_r = r; Y_i = i;
    tick();
    Y_valid = 1'b0;
  endtask

  task automatic load_frame(input int off);
    start();
    for (int k = 0; k < 16; k++) send_h(off + k, off + 100 + k);
    for (int j = 0; j < 8; j++)  send_y(off + 200 + j, off + 300 + j);
  endtask

  task automatic ack();
    frame_ack = 1'b1;
    tick();
    frame_ack = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic sel, input int addr,
                        input int er, input int ei);
    rd_sel = sel; rd_addr = 4'(addr);
    tick();
    chk({tag, "_r"}, rd_r, er);
    chk({tag, "_i"}, rd_i, ei);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    sw_0 = 1'b0; sys_start = 0; H_valid = 0; Y_valid = 0; frame_ack = 0;
    rd_sel = 0; rd_addr = 0; H_r = 0; H_i = 0; Y_r = 0; Y_i = 0;
    repeat (2) @(posedge CLOCK_50);
    #1;
    chk("rst_ready", frame_ready, 0);
    chk("rst_done", frames_done, 0);
    chk("rst_rd_r", rd_r, 0);
    chk("rst_seq", seq_err, 0);
    sw_0 = 1'b1;
    tick();

    // basic frame
    start();
    for (int k = 0; k < 16; k++) send_h(k, 100 + k);
    for (int j = 0; j < 7; j++)  send_y(200 + j, 300 + j);
    chk("ready_early", frame_ready, 0);
    send_y(207, 307);
    chk("ready_rise", frame_ready, 1);
    rd_chk("basic_h5", 0, 5, 5, 105);
    rd_chk("basic_y7", 1, 7, 207, 307);
    rd_chk("basic_y9", 1, 9, 0, 0);
    chk("basic_seq", seq_err, 0);
    chk("basic_drop", drop_err, 0);

    // ack release
    ack();
    chk("ack_ready", frame_ready, 0);
    chk("ack_done", frames_done, 1);
    repeat (3) tick();
    chk("ack_stay_low", frame_ready, 0);

    // ping-pong: A into bank 1, B into bank 0
    load_frame(0);
    load_frame(1000);
    chk("pp_ready", frame_ready, 1);
    rd_chk("pp_a_h0", 0, 0, 0, 100);
    ack();
    chk("pp_gap", frame_ready, 0);
    tick();
    chk("pp_back", frame_ready, 1);
    rd_chk("pp_b_h0", 0, 0, 1000, 1100);
    chk("pp_done", frames_done, 2);

    // overrun: C fills bank 1, third frame must be dropped
    load_frame(2000);
    chk("ovr_drop_pre", drop_err, 0);
    start();
    chk("ovr_start_drop", drop_err, 1);
    for (int k = 0; k < 16; k++) send_h(3000 + k, 3100 + k);
    for (int j = 0; j < 8; j++)  send_y(3200 + j, 3300 + j);
    chk("ovr_drop", drop_err, 1);
    chk("ovr_seq", seq_err, 0);
    rd_chk("ovr_b_h0", 0, 0, 1000, 1100);
    rd_chk("ovr_b_y3", 1, 3, 1203, 1303);
    ack();
    tick();
    chk("ovr_ready_c", frame_ready, 1);
    rd_chk("ovr_c_h15", 0, 15, 2015, 2115);
    rd_chk("ovr_c_y0", 1, 0, 2200, 2300);
    ack();
    chk("ovr_done", frames_done, 4);
    tick();
    chk("ovr_empty", frame_ready, 0);

    // sequencing errors
    start();
    chk("seq_drop_clr", drop_err, 0);
    for (int k = 0; k < 10; k++) send_h(500 + k, 600 + k);
    send_y(7777, 7777);
    chk("seq_early_y", seq_err, 1);
    for (int k = 10; k < 16; k++) send_h(500 + k, 600 + k);
    send_h(9999, 9999);
    for (int j = 0; j < 8; j++) send_y(700 + j, 800 + j);
    chk("seq_ready", frame_ready, 1);
    rd_chk("seq_h9", 0, 9, 509, 609);
    rd_chk("seq_h10", 0, 10, 510, 610);
    rd_chk("seq_y0", 1, 0, 700, 800);
    rd_chk("seq_y7", 1, 7, 707, 807);
    ack();
    start();
    chk("seq_clr", seq_err, 0);
    for (int k = 0; k < 16; k++) send_h(k, k);
    send_h(9999, 9999);
    chk("seq_17th", seq_err, 1);

    // abort after 20 elements, then a full frame
    for (int j = 0; j < 3; j++) send_y(8000 + j, 8000 + j);
    load_frame(5000);
    chk("abort_seq", seq_err, 0);
    chk("abort_ready", frame_ready, 1);
    rd_chk("abort_h0", 0, 0, 5000, 5100);
    rd_chk("abort_y0", 1, 0, 5200, 5300);
    rd_chk("abort_y7", 1, 7, 5207, 5307);
    chk("abort_done", frames_done, 5);

    // asynchronous reset mid-frame
    start();
    for (int k = 0; k < 5; k++) send_h(k, k);
    send_y(1, 1);
    chk("pre_rst_seq", seq_err, 1);
    sw_0 = 1'b0;
    #1;
    chk("arst_ready", frame_ready, 0);
    chk("arst_done", frames_done, 0);
    chk("arst_rd_r", rd_r, 0);
    chk("arst_rd_i", rd_i, 0);
    chk("arst_seq", seq_err, 0);
    tick();
    sw_0 = 1'b1;
    tick();
    load_frame(0);
    chk("post_rst_ready", frame_ready, 1);
    rd_chk("post_rst_h5", 0, 5, 5, 105);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
